// File: rtl/dmem_arbiter_pkg.sv
// dmem_arb_pkg: shared types and constants for the data-memory arbiter
package dmem_arb_pkg;
  localparam int DEF_ADDR_W = 8;
  localparam int DEF_DATA_W = 8;
  localparam logic PORT_MEM = 1'b0;
  localparam logic PORT_DBG = 1'b1;
  typedef enum logic [1:0] {IDLE, BYTE0, BYTE1, RESP} state_t;
endpackage

// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: requester handshake plus memory pin bundle
interface dmem_arbiter_if #(parameter int ADDR_W = 8, parameter int DATA_W = 8);
  logic [1:0] req;
  logic [1:0] we;
  logic [1:0] wide;
  logic [ADDR_W-1:0] addr0;
  logic [ADDR_W-1:0] addr1;
  logic [2*DATA_W-1:0] wdata0;
  logic [2*DATA_W-1:0] wdata1;
  logic [1:0] gnt;
  logic [1:0] done;
  logic [2*DATA_W-1:0] rdata;
  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_writeData;
  logic mem_read;
  logic mem_write;
  logic [DATA_W-1:0] mem_readData;
  modport slave (
    input req, we, wide, addr0, addr1, wdata0, wdata1, mem_readData,
    output gnt, done, rdata, mem_address, mem_writeData, mem_read, mem_write
  );
  modport master (
    output req, we, wide, addr0, addr1, wdata0, wdata1, mem_readData,
    input gnt, done, rdata, mem_address, mem_writeData, mem_read, mem_write
  );
endinterface

// File: rtl/rr_arbiter2.sv
// rr_arbiter2: two-way round-robin / fixed-priority arbiter with last-grant pointer
module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req_i,
  input  logic       fixed_prio_i,
  input  logic       advance_i,
  output logic [1:0] grant_o
);
  logic last_q;
  // contention goes to port 0 under fixed priority or when port 1 won last
  always_comb grant_o = (req_i == 2'b11) ? ((fixed_prio_i || last_q) ? 2'b01 : 2'b10) : req_i;
  // pointer starts at port 1 so port 0 wins the first contention
  always_ff @(posedge clk)
    if (rst) last_q <= 1'b1;
    else if (advance_i && |grant_o) last_q <= grant_o[1];
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: serialises two requesters' byte/word accesses onto a single-port byte memory
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int FIXED_PRIO = 0
) (
  input logic clk,
  input logic rst,
  dmem_arbiter_if.slave bus
);
  state_t state_q;
  logic id_q, we_q, wide_q;
  logic [ADDR_W-1:0] addr_q, mem_address_q, sel_addr;
  logic [2*DATA_W-1:0] wdata_q, rdata_q, sel_wdata;
  logic [DATA_W-1:0] mem_writeData_q;
  logic mem_read_q, mem_write_q;
  logic [1:0] gnt_q, done_q, grant;
  logic win;
  rr_arbiter2 u_arb (
    .clk          (clk),
    .rst          (rst),
    .req_i        (bus.req),
    .fixed_prio_i (FIXED_PRIO != 0),
    .advance_i    (state_q == IDLE),
    .grant_o      (grant)
  );
  // winner's fields, sampled only in IDLE
  always_comb begin
    win       = grant[PORT_DBG];
    sel_addr  = win ? bus.addr1 : bus.addr0;
    sel_wdata = win ? bus.wdata1 : bus.wdata0;
  end
  // single FSM: memory pins are registered so they are set up on entry to BYTE0/BYTE1
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= IDLE;
      id_q            <= 1'b0;
      we_q            <= 1'b0;
      wide_q          <= 1'b0;
      addr_q          <= '0;
      wdata_q         <= '0;
      rdata_q         <= '0;
      gnt_q           <= '0;
      done_q          <= '0;
      mem_address_q   <= '0;
      mem_writeData_q <= '0;
      mem_read_q      <= 1'b0;
      mem_write_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (|bus.req) begin
          state_q         <= BYTE0;
          id_q            <= win;
          we_q            <= bus.we[win];
          wide_q          <= bus.wide[win];
          addr_q          <= sel_addr;
          wdata_q         <= sel_wdata;
          gnt_q           <= grant;
          mem_address_q   <= sel_addr;
          mem_writeData_q <= sel_wdata[DATA_W-1:0];
          mem_read_q      <= !bus.we[win];
          mem_write_q     <= bus.we[win];
        end
        BYTE0: begin
          if (!we_q) rdata_q[DATA_W-1:0] <= bus.mem_readData;
          if (wide_q) begin
            state_q         <= BYTE1;
            mem_address_q   <= addr_q + ADDR_W'(1);
            mem_writeData_q <= wdata_q[2*DATA_W-1:DATA_W];
          end else begin
            if (!we_q) rdata_q[2*DATA_W-1:DATA_W] <= '0;
            state_q         <= RESP;
            done_q[id_q]    <= 1'b1;
            mem_address_q   <= '0;
            mem_writeData_q <= '0;
            mem_read_q      <= 1'b0;
            mem_write_q     <= 1'b0;
          end
        end
        BYTE1: begin
          if (!we_q) rdata_q[2*DATA_W-1:DATA_W] <= bus.mem_readData;
          state_q         <= RESP;
          done_q[id_q]    <= 1'b1;
          mem_address_q   <= '0;
          mem_writeData_q <= '0;
          mem_read_q      <= 1'b0;
          mem_write_q     <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          done_q  <= '0;
          gnt_q   <= '0;
        end
      endcase
    end
  end
  // strobes are gated by rst so a reset landing in BYTE1 suppresses the high-byte write
  always_comb begin
    bus.gnt           = gnt_q;
    bus.done          = done_q;
    bus.rdata         = rdata_q;
    bus.mem_address   = mem_address_q;
    bus.mem_writeData = mem_writeData_q;
    bus.mem_read      = mem_read_q & ~rst;
    bus.mem_write     = mem_write_q & ~rst;
  end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed scoreboard bench for dmem_arbiter
module tb_dmem_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  dmem_arbiter_if bus ();
  dmem_arbiter_if fbus ();
  dmem_arbiter #(.FIXED_PRIO(0)) dut (.clk(clk), .rst(rst), .bus(bus));
  dmem_arbiter #(.FIXED_PRIO(1)) dut_fp (.clk(clk), .rst(rst), .bus(fbus));
  typedef struct {logic [1:0] done; logic [15:0] rdata;} exp_t;
  exp_t sb[$];
  logic [7:0] ram [256];
  logic [7:0] rd_log[$];
  int wr_cnt = 0;
  int vecs = 0;
  int errs = 0;
  logic [1:0] prev_done = '0;
  assign bus.mem_readData  = ram[bus.mem_address];
  assign fbus.mem_readData = 8'h00;
  always @(posedge clk) if (bus.mem_write) ram[bus.mem_address] <= bus.mem_writeData;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  always @(negedge clk) begin
    exp_t e;
    if (bus.mem_read) rd_log.push_back(bus.mem_address);
    if (bus.mem_write) wr_cnt++;
    if (bus.mem_read | bus.mem_write) chk("rw_excl", 32'(bus.mem_read & bus.mem_write), 0);
    if (|bus.done) begin
      chk("done_width", 32'(prev_done & bus.done), 0);
      if (sb.size() == 0) chk("spurious_done", 32'(bus.done), 0);
      else begin
        e = sb.pop_front();
        chk("done_port", 32'(bus.done), 32'(e.done));
        chk("rdata", 32'(bus.rdata), 32'(e.rdata));
      end
    end
    prev_done = bus.done;
  end
  task automatic chk_idle(input string tag);
    chk({tag, "_rdata"}, 32'(bus.rdata), 0);
    chk({tag, "_ctl"}, 32'({bus.gnt, bus.done, bus.mem_read, bus.mem_write}), 0);
    chk({tag, "_pins"}, 32'({bus.mem_address, bus.mem_writeData}), 0);
  endtask
  task automatic do_req(input int p, input logic w, input logic wd, input logic [7:0] a,
                        input logic [15:0] d, input int lat, input logic [15:0] exp_rd);
    int n;
    bit got;
    @(posedge clk); #1;
    if (p == 0) begin bus.addr0 = a; bus.wdata0 = d; end
    else begin bus.addr1 = a; bus.wdata1 = d; end
    bus.we[p] = w;
    bus.wide[p] = wd;
    bus.req[p] = 1'b1;
    sb.push_back('{done: 2'(1 << p), rdata: exp_rd});
    n = 0;
    got = 0;
    while (!got && n < 10) begin
      @(negedge clk);
      if (bus.done[p]) got = 1;
      else n++;
    end
    chk("latency", 32'(n), 32'(lat));
    @(posedge clk); #1;
    bus.req[p] = 1'b0;
  endtask
  initial begin
    int n, k, g1, d0;
    bit got;
    {bus.req, bus.we, bus.wide} = '0;
    {bus.addr0, bus.addr1, bus.wdata0, bus.wdata1} = '0;
    {fbus.req, fbus.we, fbus.wide} = '0;
    {fbus.addr0, fbus.addr1, fbus.wdata0, fbus.wdata1} = '0;
    for (int i = 0; i < 256; i++) ram[i] = 8'h00;
    ram[102] = 8'h80;
    ram[103] = 8'h0A;
    ram[10]  = 8'hC3;
    ram[20]  = 8'h11;
    ram[51]  = 8'h77;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk_idle("reset");
    rd_log.delete();
    do_req(0, 1'b0, 1'b1, 8'd102, 16'h0000, 3, 16'h0A80);
    chk("rd_cycles", 32'(rd_log.size()), 2);
    chk("rd_addr0", 32'(rd_log[0]), 102);
    chk("rd_addr1", 32'(rd_log[1]), 103);
    wr_cnt = 0;
    do_req(1, 1'b1, 1'b0, 8'd255, 16'h005A, 2, 16'h0A80);
    chk("wr_cycles", 32'(wr_cnt), 1);
    chk("ram255_byte", 32'(ram[255]), 32'h5A);
    do_req(1, 1'b0, 1'b0, 8'd255, 16'h0000, 2, 16'h005A);
    do_req(0, 1'b1, 1'b1, 8'd255, 16'hBEEF, 3, 16'h005A);
    chk("ram255_lo", 32'(ram[255]), 32'hEF);
    chk("ram0_wrap", 32'(ram[0]), 32'hBE);
    do_req(0, 1'b0, 1'b1, 8'd255, 16'h0000, 3, 16'hBEEF);
    @(posedge clk); #1;
    bus.addr0 = 8'd102;
    bus.addr1 = 8'd103;
    bus.we = 2'b00;
    bus.wide = 2'b00;
    bus.req = 2'b11;
    sb.push_back('{done: 2'b10, rdata: 16'h000A});
    sb.push_back('{done: 2'b01, rdata: 16'h0080});
    sb.push_back('{done: 2'b10, rdata: 16'h000A});
    sb.push_back('{done: 2'b01, rdata: 16'h0080});
    k = 0;
    n = 0;
    while (k < 4 && n < 40) begin
      @(negedge clk);
      n++;
      chk("gnt_onehot", 32'($onehot0(bus.gnt)), 1);
      if (|bus.done) k++;
    end
    chk("rr_done_cnt", 32'(k), 4);
    @(posedge clk); #1;
    bus.req = 2'b00;
    chk("rr_sb_empty", 32'(sb.size()), 0);
    @(posedge clk); #1;
    fbus.addr0 = 8'd1;
    fbus.addr1 = 8'd2;
    fbus.req = 2'b11;
    g1 = 0;
    d0 = 0;
    repeat (24) begin
      @(negedge clk);
      if (fbus.gnt[1]) g1++;
      if (fbus.done[0]) d0++;
    end
    chk("fp_no_gnt1", 32'(g1), 0);
    chk("fp_done0", 32'(d0), 8);
    @(posedge clk); #1;
    fbus.req[0] = 1'b0;
    got = 0;
    n = 0;
    while (!got && n < 10) begin
      @(negedge clk);
      n++;
      if (fbus.done[1]) got = 1;
    end
    chk("fp_port1_served", 32'(got), 1);
    @(posedge clk); #1;
    fbus.req = 2'b00;
    do_req(0, 1'b0, 1'b1, 8'd102, 16'h0000, 3, 16'h0A80);
    rd_log.delete();
    @(posedge clk); #1;
    bus.addr1 = 8'd10;
    bus.we[1] = 1'b0;
    bus.wide[1] = 1'b0;
    bus.req[1] = 1'b1;
    sb.push_back('{done: 2'b10, rdata: 16'h00C3});
    @(posedge clk); #1;
    bus.addr1 = 8'd20;
    got = 0;
    n = 0;
    while (!got && n < 10) begin
      @(negedge clk);
      n++;
      if (bus.done[1]) got = 1;
    end
    chk("chg_done", 32'(got), 1);
    chk("chg_rdata_hi", 32'(bus.rdata[15:8]), 0);
    chk("chg_rd_cycles", 32'(rd_log.size()), 1);
    chk("chg_rd_addr", 32'(rd_log[0]), 10);
    @(posedge clk); #1;
    bus.req = 2'b00;
    @(posedge clk); #1;
    bus.addr0 = 8'd50;
    bus.wdata0 = 16'h1234;
    bus.we[0] = 1'b1;
    bus.wide[0] = 1'b1;
    bus.req[0] = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    bus.req = 2'b00;
    @(negedge clk);
    chk_idle("mid_rst");
    chk("ram50_lo", 32'(ram[50]), 32'h34);
    chk("ram51_kept", 32'(ram[51]), 32'h77);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (4) @(negedge clk);
    chk_idle("after_rst");
    chk("sb_drained", 32'(sb.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
